// File: rtl/cle_pkg.sv
// Shared constants, state encoding and address helpers for the labeller back end.
package cle_pkg;

    localparam int IMG_W   = 32;
    localparam int IMG_H   = 32;
    localparam int NPIX    = IMG_W * IMG_H;
    localparam int ADDR_W  = 10;
    localparam int LABEL_W = 8;
    localparam int AREA_W  = 11;
    localparam int COORD_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SCAN,
        ST_EMIT,
        ST_DONE
    } state_t;

    // Label map address is {y, x}.
    function automatic logic [COORD_W-1:0] addr_x(input logic [ADDR_W-1:0] a);
        return a[COORD_W-1:0];
    endfunction

    function automatic logic [COORD_W-1:0] addr_y(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:COORD_W];
    endfunction

endpackage

// File: rtl/cle_stats_acc.sv
// Per-label area / bounding-box register file with update, clear and read ports.
// Bounding-box storage exists only when CLE_STATS_BBOX_EN is defined.
module cle_stats_acc
    import cle_pkg::*;
#(
    parameter int MAX_LABEL = 31
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               upd_en,
    input  logic [LABEL_W-1:0] upd_label,
`ifdef CLE_STATS_BBOX_EN
    input  logic [COORD_W-1:0] upd_x,
    input  logic [COORD_W-1:0] upd_y,
    output logic [COORD_W-1:0] rd_xmin,
    output logic [COORD_W-1:0] rd_xmax,
    output logic [COORD_W-1:0] rd_ymin,
    output logic [COORD_W-1:0] rd_ymax,
`endif
    input  logic [LABEL_W-1:0] rd_label,
    output logic [AREA_W-1:0]  rd_area
);

    logic [AREA_W-1:0]  area_arr [1:MAX_LABEL];
`ifdef CLE_STATS_BBOX_EN
    logic [COORD_W-1:0] xmin_arr [1:MAX_LABEL];
    logic [COORD_W-1:0] xmax_arr [1:MAX_LABEL];
    logic [COORD_W-1:0] ymin_arr [1:MAX_LABEL];
    logic [COORD_W-1:0] ymax_arr [1:MAX_LABEL];
`endif

    generate
        for (genvar gi = 1; gi <= MAX_LABEL; gi++) begin : g_ent
            logic              hit;
            logic [AREA_W-1:0] area_q, area_d;

            assign hit          = upd_en && (upd_label == LABEL_W'(gi));
            assign area_arr[gi] = area_q;

            always_comb begin
                area_d = area_q;
                if (clr) begin
                    area_d = '0;
                end else if (hit) begin
                    area_d = area_q + 1'b1;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    area_q <= '0;
                end else begin
                    area_q <= area_d;
                end
            end

`ifdef CLE_STATS_BBOX_EN
            logic [COORD_W-1:0] xmin_q, xmin_d, xmax_q, xmax_d;
            logic [COORD_W-1:0] ymin_q, ymin_d, ymax_q, ymax_d;

            assign xmin_arr[gi] = xmin_q;
            assign xmax_arr[gi] = xmax_q;
            assign ymin_arr[gi] = ymin_q;
            assign ymax_arr[gi] = ymax_q;

            // Box needs no clearing: the first pixel of a pass (area 0) seeds it.
            always_comb begin
                xmin_d = xmin_q;
                xmax_d = xmax_q;
                ymin_d = ymin_q;
                ymax_d = ymax_q;
                if (hit) begin
                    if (area_q == '0) begin
                        xmin_d = upd_x;
                        xmax_d = upd_x;
                        ymin_d = upd_y;
                        ymax_d = upd_y;
                    end else begin
                        if (upd_x < xmin_q) xmin_d = upd_x;
                        if (upd_x > xmax_q) xmax_d = upd_x;
                        if (upd_y < ymin_q) ymin_d = upd_y;
                        if (upd_y > ymax_q) ymax_d = upd_y;
                    end
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    xmin_q <= '0;
                    xmax_q <= '0;
                    ymin_q <= '0;
                    ymax_q <= '0;
                end else begin
                    xmin_q <= xmin_d;
                    xmax_q <= xmax_d;
                    ymin_q <= ymin_d;
                    ymax_q <= ymax_d;
                end
            end
`endif
        end
    endgenerate

    always_comb begin
        rd_area = '0;
`ifdef CLE_STATS_BBOX_EN
        rd_xmin = '0;
        rd_xmax = '0;
        rd_ymin = '0;
        rd_ymax = '0;
`endif
        for (int i = 1; i <= MAX_LABEL; i++) begin
            if (rd_label == LABEL_W'(i)) begin
                rd_area = area_arr[i];
`ifdef CLE_STATS_BBOX_EN
                rd_xmin = xmin_arr[i];
                rd_xmax = xmax_arr[i];
                rd_ymin = ymin_arr[i];
                rd_ymax = ymax_arr[i];
`endif
            end
        end
    end

endmodule

// File: rtl/cle_stats.sv
// Label-map statistics: scans the 32x32 label SRAM and streams one area/bbox record
// per non-empty label. Define CLE_STATS_BBOX_EN to build bounding-box tracking.
module cle_stats
    import cle_pkg::*;
#(
    parameter int MAX_LABEL = 31
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [ADDR_W-1:0]  sram_a,
    input  logic [LABEL_W-1:0] sram_q,
    output logic               busy,
    output logic               rec_valid,
    input  logic               rec_ready,
    output logic [LABEL_W-1:0] rec_label,
    output logic [AREA_W-1:0]  rec_area,
    output logic [COORD_W-1:0] rec_xmin,
    output logic [COORD_W-1:0] rec_xmax,
    output logic [COORD_W-1:0] rec_ymin,
    output logic [COORD_W-1:0] rec_ymax,
    output logic               overflow,
    output logic               done
);

    localparam logic [LABEL_W-1:0] MAX_L     = LABEL_W'(MAX_LABEL);
    localparam logic [ADDR_W:0]    SCAN_LAST = (ADDR_W + 1)'(NPIX);

    state_t             state_q, state_d;
    logic [ADDR_W:0]    scan_cnt_q, scan_cnt_d;
    logic               pix_valid_q, pix_valid_d;
    logic [LABEL_W-1:0] idx_q, idx_d;
    logic               overflow_q, overflow_d;

    logic               acc_clr;
    logic               upd_en;
    logic [AREA_W-1:0]  rd_area;

`ifdef CLE_STATS_BBOX_EN
    logic [ADDR_W-1:0]  pix_addr_q, pix_addr_d;
    logic [COORD_W-1:0] rd_xmin, rd_xmax, rd_ymin, rd_ymax;
`endif

    // Read data lags the address by one cycle; pix_valid_q marks a live datum.
    assign upd_en = pix_valid_q && (sram_q != '0) && (sram_q <= MAX_L);

    always_comb begin
        state_d     = state_q;
        scan_cnt_d  = scan_cnt_q;
        pix_valid_d = 1'b0;
        idx_d       = idx_q;
        overflow_d  = overflow_q;
        acc_clr     = 1'b0;
`ifdef CLE_STATS_BBOX_EN
        pix_addr_d  = pix_addr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_CLEAR;
                    overflow_d = 1'b0;
                end
            end
            ST_CLEAR: begin
                acc_clr    = 1'b1;
                scan_cnt_d = '0;
                state_d    = ST_SCAN;
            end
            ST_SCAN: begin
                pix_valid_d = (scan_cnt_q != SCAN_LAST);
`ifdef CLE_STATS_BBOX_EN
                pix_addr_d  = scan_cnt_q[ADDR_W-1:0];
`endif
                if (scan_cnt_q == SCAN_LAST) begin
                    scan_cnt_d = '0;
                    idx_d      = LABEL_W'(1);
                    state_d    = ST_EMIT;
                end else begin
                    scan_cnt_d = scan_cnt_q + 1'b1;
                end
            end
            ST_EMIT: begin
                if (!rec_valid || rec_ready) begin
                    if (idx_q == MAX_L) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (pix_valid_q && (sram_q > MAX_L)) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            scan_cnt_q  <= '0;
            pix_valid_q <= 1'b0;
            idx_q       <= '0;
            overflow_q  <= 1'b0;
`ifdef CLE_STATS_BBOX_EN
            pix_addr_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            scan_cnt_q  <= scan_cnt_d;
            pix_valid_q <= pix_valid_d;
            idx_q       <= idx_d;
            overflow_q  <= overflow_d;
`ifdef CLE_STATS_BBOX_EN
            pix_addr_q  <= pix_addr_d;
`endif
        end
    end

    cle_stats_acc #(
        .MAX_LABEL (MAX_LABEL)
    ) u_acc (
        .clk       (clk),
        .reset     (reset),
        .clr       (acc_clr),
        .upd_en    (upd_en),
        .upd_label (sram_q),
`ifdef CLE_STATS_BBOX_EN
        .upd_x     (addr_x(pix_addr_q)),
        .upd_y     (addr_y(pix_addr_q)),
        .rd_xmin   (rd_xmin),
        .rd_xmax   (rd_xmax),
        .rd_ymin   (rd_ymin),
        .rd_ymax   (rd_ymax),
`endif
        .rd_label  (idx_q),
        .rd_area   (rd_area)
    );

    assign sram_a    = scan_cnt_q[ADDR_W-1:0];
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign overflow  = overflow_q;
    assign rec_valid = (state_q == ST_EMIT) && (rd_area != '0);
    assign rec_label = rec_valid ? idx_q : '0;
    assign rec_area  = rec_valid ? rd_area : '0;

`ifdef CLE_STATS_BBOX_EN
    assign rec_xmin  = rec_valid ? rd_xmin : '0;
    assign rec_xmax  = rec_valid ? rd_xmax : '0;
    assign rec_ymin  = rec_valid ? rd_ymin : '0;
    assign rec_ymax  = rec_valid ? rd_ymax : '0;
`else
    assign rec_xmin  = '0;
    assign rec_xmax  = COORD_W'(IMG_W - 1);
    assign rec_ymin  = '0;
    assign rec_ymax  = COORD_W'(IMG_H - 1);
`endif

endmodule

// File: tb/tb_cle_stats.sv
// Randomized self-checking bench for cle_stats against a per-label reference model.
module tb_cle_stats;

    localparam int MAXL     = 31;
    localparam int DONE_LAT = 1025 + MAXL + 2;

    typedef struct packed {
        logic [7:0]  label;
        logic [10:0] area;
        logic [4:0]  xmin;
        logic [4:0]  xmax;
        logic [4:0]  ymin;
        logic [4:0]  ymax;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  sram_a;
    logic [7:0]  sram_q = 8'd0;
    logic        busy;
    logic        rec_valid;
    logic        rec_ready;
    logic [7:0]  rec_label;
    logic [10:0] rec_area;
    logic [4:0]  rec_xmin, rec_xmax, rec_ymin, rec_ymax;
    logic        overflow;
    logic        done;

    logic [7:0]  mem [1024];

    rec_t exp_q[$];
    rec_t got_q[$];
    bit   exp_ovf;
    int   done_cyc, stall_seen, stable_viol, drop_viol;
    bit   timed_out, ovf_early, ovf_end;
    int   checks = 0;
    int   failures = 0;

    cle_stats #(.MAX_LABEL(MAXL)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .sram_a    (sram_a),
        .sram_q    (sram_q),
        .busy      (busy),
        .rec_valid (rec_valid),
        .rec_ready (rec_ready),
        .rec_label (rec_label),
        .rec_area  (rec_area),
        .rec_xmin  (rec_xmin),
        .rec_xmax  (rec_xmax),
        .rec_ymin  (rec_ymin),
        .rec_ymax  (rec_ymax),
        .overflow  (overflow),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) sram_q <= mem[sram_a];

    function automatic rec_t mk_rec(input int l, input int a, input int x0, input int x1,
                                    input int y0, input int y1);
        rec_t r;
        r.label = 8'(l);
        r.area  = 11'(a);
`ifdef CLE_STATS_BBOX_EN
        r.xmin = 5'(x0); r.xmax = 5'(x1); r.ymin = 5'(y0); r.ymax = 5'(y1);
`else
        r.xmin = 5'd0; r.xmax = 5'd31; r.ymin = 5'd0; r.ymax = 5'd31;
`endif
        return r;
    endfunction

    // Reference: for each label, count its pixels and take coordinate extremes.
    function automatic void build_model();
        int n, x0, x1, y0, y1;
        exp_q.delete();
        exp_ovf = 1'b0;
        for (int i = 0; i < 1024; i++) if (int'(mem[i]) > MAXL) exp_ovf = 1'b1;
        for (int l = 1; l <= MAXL; l++) begin
            n = 0; x0 = 31; x1 = 0; y0 = 31; y1 = 0;
            for (int i = 0; i < 1024; i++) begin
                if (int'(mem[i]) == l) begin
                    n++;
                    if (i % 32 < x0) x0 = i % 32;
                    if (i % 32 > x1) x1 = i % 32;
                    if (i / 32 < y0) y0 = i / 32;
                    if (i / 32 > y1) y1 = i / 32;
                end
            end
            if (n > 0) exp_q.push_back(mk_rec(l, n, x0, x1, y0, y1));
        end
    endfunction

    function automatic void clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 8'd0;
    endfunction

    function automatic void random_mem(input int density, input bit with_big);
        for (int i = 0; i < 1024; i++) begin
            if ($urandom_range(99) < density) mem[i] = 8'($urandom_range(1, MAXL));
            else mem[i] = 8'd0;
        end
        if (with_big) begin
            mem[$urandom_range(1023)] = 8'd40;
            mem[$urandom_range(1023)] = 8'd200;
        end
    endfunction

    // mode 0: always ready; mode 1: random ready. hold: stall cycles on first record.
    task automatic run_pass(input int mode, input int hold);
        rec_t cur, snap;
        bit have_snap, first_done, prev_valid, prev_hs;
        got_q.delete();
        stall_seen = 0; stable_viol = 0; drop_viol = 0; done_cyc = -1; timed_out = 1'b0;
        have_snap = 1'b0; first_done = 1'b0; prev_valid = 1'b0; prev_hs = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        ovf_early = overflow;
        for (int cyc = 1; cyc < 8000; cyc++) begin
            if (done) begin
                done_cyc = cyc;
                break;
            end
            rec_ready = (mode == 1) ? (($urandom % 3) != 0) : 1'b1;
            if (!first_done && stall_seen < hold && rec_valid) rec_ready = 1'b0;
            cur = {rec_label, rec_area, rec_xmin, rec_xmax, rec_ymin, rec_ymax};
            if (prev_valid && !prev_hs && !rec_valid) drop_viol++;
            if (rec_valid) begin
                if (have_snap && cur !== snap) stable_viol++;
                if (!rec_ready) begin
                    if (!have_snap) begin snap = cur; have_snap = 1'b1; end
                    if (!first_done) stall_seen++;
                end else begin
                    got_q.push_back(cur);
                    first_done = 1'b1;
                    have_snap = 1'b0;
                end
            end
            prev_valid = rec_valid;
            prev_hs = rec_valid && rec_ready;
            @(negedge clk);
        end
        ovf_end = overflow;
        rec_ready = 1'b1;
        if (done_cyc < 0) timed_out = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; rec_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({sram_a, busy, rec_valid, rec_label, rec_area, overflow, done} !== 33'd0) begin
            failures++;
            $display("FAIL reset_outputs: got a=%0d busy=%0d v=%0d lbl=%0d area=%0d ovf=%0d done=%0d required all 0",
                     sram_a, busy, rec_valid, rec_label, rec_area, overflow, done);
        end
        checks++;
`ifdef CLE_STATS_BBOX_EN
        if ({rec_xmin, rec_xmax, rec_ymin, rec_ymax} !== 20'd0) begin
`else
        if ({rec_xmin, rec_xmax, rec_ymin, rec_ymax} !== {5'd0, 5'd31, 5'd0, 5'd31}) begin
`endif
            failures++;
            $display("FAIL reset_bbox: got %0d %0d %0d %0d", rec_xmin, rec_xmax, rec_ymin, rec_ymax);
        end
        reset = 1'b0;
        @(negedge clk);
        $display("test_reset: done");
    endtask

    task automatic test_blank();
        clear_mem();
        run_pass(0, 0);
        checks++;
        if (timed_out || done_cyc != DONE_LAT) begin
            failures++;
            $display("FAIL blank_latency: got %0d required %0d", done_cyc, DONE_LAT);
        end
        checks++;
        if (got_q.size() != 0) begin
            failures++;
            $display("FAIL blank_records: got %0d required 0", got_q.size());
        end
        checks++;
        if (ovf_end !== 1'b0) begin
            failures++;
            $display("FAIL blank_overflow: got %0d required 0", ovf_end);
        end
        $display("test_blank: done_cyc=%0d records=%0d", done_cyc, got_q.size());
    endtask

    task automatic test_single();
        rec_t want;
        clear_mem();
        mem[1023] = 8'd1;
        want = mk_rec(1, 1, 31, 31, 31, 31);
        run_pass(0, 0);
        checks++;
        if (timed_out || got_q.size() != 1) begin
            failures++;
            $display("FAIL single_count: got %0d required 1 (timeout=%0d)", got_q.size(), timed_out);
        end else begin
            checks++;
            if (got_q[0] !== want) begin
                failures++;
                $display("FAIL single_rec: got %h required %h", got_q[0], want);
            end
        end
        $display("test_single: records=%0d", got_q.size());
    endtask

    task automatic test_blocks();
        rec_t want[2];
        clear_mem();
        for (int y = 10; y <= 12; y++) for (int x = 4; x <= 5; x++) mem[y * 32 + x] = 8'd1;
        for (int x = 0; x < 32; x++) mem[x] = 8'd3;
        want[0] = mk_rec(1, 6, 4, 5, 10, 12);
        want[1] = mk_rec(3, 32, 0, 31, 0, 0);
        run_pass(0, 0);
        checks++;
        if (timed_out || got_q.size() != 2) begin
            failures++;
            $display("FAIL blocks_count: got %0d required 2", got_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (got_q[i] !== want[i]) begin
                    failures++;
                    $display("FAIL blocks_rec%0d: got %h required %h", i, got_q[i], want[i]);
                end
            end
        end
        checks++;
        if (done_cyc != DONE_LAT) begin
            failures++;
            $display("FAIL blocks_latency: got %0d required %0d", done_cyc, DONE_LAT);
        end
        $display("test_blocks: records=%0d done_cyc=%0d", got_q.size(), done_cyc);
    endtask

    task automatic test_overflow();
        random_mem(20, 1'b1);
        build_model();
        run_pass(0, 0);
        checks++;
        if (ovf_end !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set: got %0d required 1", ovf_end);
        end
        checks++;
        if (timed_out || got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL ovf_count: got %0d required %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL ovf_rec%0d: got %h required %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_sticky: got %0d required 1", overflow);
        end
        clear_mem();
        run_pass(0, 0);
        checks++;
        if (ovf_early !== 1'b0 || ovf_end !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear: got early=%0d end=%0d required 0 0", ovf_early, ovf_end);
        end
        $display("test_overflow: records=%0d expected=%0d", got_q.size(), exp_q.size());
    endtask

    task automatic test_backpressure();
        random_mem(15, 1'b0);
        build_model();
        run_pass(0, 5);
        checks++;
        if (stall_seen != 5 || stable_viol != 0 || drop_viol != 0) begin
            failures++;
            $display("FAIL bp_stall: got stalls=%0d unstable=%0d drops=%0d required 5 0 0",
                     stall_seen, stable_viol, drop_viol);
        end
        checks++;
        if (timed_out || got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL bp_count: got %0d required %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL bp_rec%0d: got %h required %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        $display("test_backpressure: stalls=%0d records=%0d", stall_seen, got_q.size());
    endtask

    task automatic test_random();
        for (int p = 0; p < 3; p++) begin
            random_mem(5 + 20 * p, 1'b0);
            build_model();
            run_pass(1, 0);
            checks++;
            if (stable_viol != 0 || drop_viol != 0 || ovf_end !== exp_ovf) begin
                failures++;
                $display("FAIL rand%0d_stream: got unstable=%0d drops=%0d ovf=%0d required 0 0 %0d",
                         p, stable_viol, drop_viol, ovf_end, exp_ovf);
            end
            checks++;
            if (timed_out || got_q.size() != exp_q.size()) begin
                failures++;
                $display("FAIL rand%0d_count: got %0d required %0d", p, got_q.size(), exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    checks++;
                    if (got_q[i] !== exp_q[i]) begin
                        failures++;
                        $display("FAIL rand%0d_rec%0d: got %h required %h", p, i, got_q[i], exp_q[i]);
                    end
                end
            end
            $display("test_random pass %0d: records=%0d expected=%0d", p, got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int spurious;
        random_mem(25, 1'b0);
        build_model();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (300) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || sram_a !== 10'd0 || rec_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_abort: got busy=%0d a=%0d v=%0d required 0 0 0", busy, sram_a, rec_valid);
        end
        @(negedge clk); reset = 1'b0;
        spurious = 0;
        repeat (1100) begin
            @(negedge clk);
            if (rec_valid || done || busy) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            failures++;
            $display("FAIL midrst_quiet: got %0d active cycles required 0", spurious);
        end
        run_pass(0, 0);
        checks++;
        if (timed_out || done_cyc != DONE_LAT + exp_q.size() * 0 || got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL midrst_pass: got done_cyc=%0d n=%0d required %0d %0d",
                     done_cyc, got_q.size(), DONE_LAT, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL midrst_rec%0d: got %h required %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        $display("test_reset_mid: records=%0d", got_q.size());
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'd0;
        test_reset();
        test_blank();
        test_single();
        test_blocks();
        test_overflow();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cle_stats.md
# cle_stats

Downstream stage of the connected-component labeller. Once labelling finishes, this block scans the 32x32 label map held in the 1024-byte label SRAM. It accumulates each component's pixel area and bounding box, then emits one record per non-empty label over a valid/ready stream. It only reads the SRAM; the labeller must have released the bus before `start` is asserted.

## Interface
Parameters:
- `MAX_LABEL`, default 31: highest label value tracked; labels 1..MAX_LABEL are accumulated.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-high
- `start`  in  1  one-cycle pulse (driven by labeller `finish`); begins a pass
- `sram_a`  out  10  label SRAM read address; pixel (x,y) = addr {y[4:0],x[4:0]}
- `sram_q`  in  8  label SRAM read data; valid the cycle after `sram_a` is presented
- `busy`  out  1  high from the cycle after accepted `start` until `done`
- `rec_valid`  out  1  record available
- `rec_ready`  in  1  consumer accepts record
- `rec_label`  out  8  label of record
- `rec_area`  out  11  pixel count, 1..1024
- `rec_xmin`, `rec_xmax`, `rec_ymin`, `rec_ymax`  out  5 each  bounding box, inclusive
- `overflow`  out  1  sticky: a label > MAX_LABEL was seen this pass
- `done`  out  1  one-cycle pulse after the last record is accepted

## Operation
- States: IDLE, CLEAR, SCAN, EMIT, DONE.
- IDLE: `start`=1 -> CLEAR; clear `overflow`. `start` in any other state is ignored.
- CLEAR (1 cycle): all per-label area counters -> 0; `sram_a`=0 -> SCAN.
- SCAN: `sram_a` increments 0..1023, one per cycle. Data is processed one cycle behind the address, with pixel coordinates taken from the registered previous address.
  - label 0: no update.
  - label 1..MAX_LABEL:
    - area += 1.
    - If area was 0: xmin=xmax=x, ymin=ymax=y.
    - Else: min/max update.
  - label > MAX_LABEL: `overflow` <= 1; no update.
- SCAN lasts 1025 cycles: 1024 addresses plus 1 flush cycle for the last datum. It then moves to EMIT with label index = 1.
- EMIT:
  - Index with area 0: skip, 1 cycle per index.
  - Index with area > 0: assert `rec_valid` with fields. Fields are held stable while `rec_valid && !rec_ready`.
  - On handshake, advance the index.
  - After index MAX_LABEL is processed -> DONE.
- DONE: `done`=1 for one cycle -> IDLE. `overflow` holds its value until the next `start`.
- Area arithmetic: 11-bit unsigned; cannot wrap (max 1024).

## Timing
- Reset values: `sram_a`=0, `busy`=0, `rec_valid`=0, all `rec_*`=0, `overflow`=0, `done`=0, state IDLE.
- Reset mid-pass aborts immediately; no record or `done` follows.
- `start` -> first `sram_a`=0 issued: 2 cycles (IDLE->CLEAR->SCAN).
- Zero-backpressure pass cycle count: 1 + 1025 + MAX_LABEL + 1.
- `rec_valid` never drops without a handshake. `rec_ready` without `rec_valid` is ignored.
- Records are emitted in strictly ascending label order.

## Configuration
- `CLE_STATS_BBOX_EN` defined: bounding-box registers and min/max logic are built; `rec_x*`/`rec_y*` are as above.
- Undefined: no bounding-box storage; `rec_xmin`/`rec_ymin` are tied 0 and `rec_xmax`/`rec_ymax` are tied 31. Area, ordering and timing are unchanged.

## Structure
- Shared package `cle_pkg`: image width/height (32), address width (10), label width (8), area width (11), state encoding.
- One sub-module `cle_stats_acc`: per-label area/bbox register file. It has an update port (SCAN), a clear input and a read port (EMIT). The top holds the FSM, address counter, overflow flag and stream handshake.

## Test plan
- Blank map (all 0) -> no `rec_valid`; `done` exactly 1025+MAX_LABEL+2 cycles after `start`; `overflow`=0.
- Single pixel label 1 at addr 0x3FF -> one record: label 1, area 1, x 31..31, y 31..31 (flush cycle captured).
- Labels 1 and 3, a 2x3 block at x=4..5, y=10..12, and a full row y=0 -> records {1,6,4,5,10,12} and {3,32,0,31,0,0} in order, label 2 skipped.
- Label 40 present with MAX_LABEL=31 -> `overflow`=1 at DONE; label 40 not emitted; `overflow` clears on next `start`.
- `rec_ready` held low 5 cycles on the first record -> fields stable and `rec_valid` high throughout; the next record follows the handshake.
- Reset asserted mid-SCAN, then a new `start` -> results identical to an uninterrupted pass.
